// File: rtl/sha1_block_ctrl.sv
// SHA-1 block sequencer: accepts a 512-bit block, runs 80 rounds with an on-the-fly
// message schedule, then folds the result into the chaining value. Optional abort: SHA1_ABORT_EN.
module sha1_block_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [511:0] block_in,
    input  logic         block_first,
    input  logic         block_valid,
    output logic         block_ready,
    output logic [159:0] digest,
    output logic         digest_valid
`ifdef SHA1_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUNDS,
        S_FINAL
    } state_t;

    localparam logic [159:0] SHA1_IV =
        160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    // One combinational SHA-1 round: cv = {a,b,c,d,e}, t selects f and K.
    function automatic logic [159:0] sha1_round(input logic [159:0] cv,
                                                input logic [31:0]  w,
                                                input logic [6:0]   t);
        logic [31:0] a, b, c, d, e, f, k, tmp;
        {a, b, c, d, e} = cv;
        if (t < 7'd20) begin
            f = (b & c) | (~b & d);
            k = 32'h5a827999;
        end else if (t < 7'd40) begin
            f = b ^ c ^ d;
            k = 32'h6ed9eba1;
        end else if (t < 7'd60) begin
            f = (b & c) | (b & d) | (c & d);
            k = 32'h8f1bbcdc;
        end else begin
            f = b ^ c ^ d;
            k = 32'hca62c1d6;
        end
        tmp = {a[26:0], a[31:27]} + f + e + k + w;
        return {tmp, a, {b[1:0], b[31:2]}, c, d};
    endfunction

    state_t              state_q, state_d;
    logic [6:0]          rnd_q, rnd_d;
    logic [15:0][31:0]   w_q, w_d;
    logic [159:0]        work_q, work_d;
    logic [159:0]        base_q, base_d;
    logic [159:0]        digest_q, digest_d;
    logic                digest_valid_q, digest_valid_d;
    logic                abort_hit;
    logic [6:0]          round_idx;
    logic [159:0]        round_out;
    logic [31:0]         w_mix;

`ifdef SHA1_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Only an in-range round number is ever presented to the round stage.
    assign round_idx = (state_q == S_ROUNDS && rnd_q < 7'd80) ? rnd_q : 7'd0;
    assign round_out = sha1_round(work_q, w_q[0], round_idx);
    assign w_mix     = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];

    always_comb begin
        // NOTE: every *_d gets a default first, so no path can leave one unassigned and infer a latch.
        state_d        = state_q;
        rnd_d          = rnd_q;
        w_d            = w_q;
        work_d         = work_q;
        base_d         = base_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (block_valid && !abort_hit) begin
                    state_d = S_ROUNDS;
                    rnd_d   = 7'd0;
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in[511 - 32*i -: 32];
                    end
                    work_d = block_first ? SHA1_IV : digest_q;
                    base_d = block_first ? SHA1_IV : digest_q;
                end
            end
            S_ROUNDS: begin
                if (abort_hit) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = round_out;
                    for (int i = 0; i < 15; i++) begin
                        w_d[i] = w_q[i+1];
                    end
                    w_d[15] = {w_mix[30:0], w_mix[31]};
                    rnd_d   = rnd_q + 7'd1;
                    if (rnd_q == 7'd79) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                state_d = S_IDLE;
                if (!abort_hit) begin
                    // Per-word modular add; carries must not cross 32-bit word boundaries.
                    for (int i = 0; i < 5; i++) begin
                        digest_d[32*i +: 32] = base_q[32*i +: 32] + work_q[32*i +: 32];
                    end
                    digest_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the schedule and working registers are plain flops, so they reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rnd_q          <= 7'd0;
            w_q            <= '0;
            work_q         <= '0;
            base_q         <= '0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            rnd_q          <= rnd_d;
            w_q            <= w_d;
            work_q         <= work_d;
            base_q         <= base_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign block_ready  = (state_q == S_IDLE);
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha1_block_ctrl.sv
// Scoreboard bench for sha1_block_ctrl: driver pushes expected digests and pulse edges,
// a negedge monitor pops and compares whenever digest_valid is seen.
module tb_sha1_block_ctrl;

    typedef struct {
        int           edge_no;
        bit           chk;
        logic [159:0] dig;
    } exp_t;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] DIG_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] block_in;
    logic         block_first;
    logic         block_valid;
    logic         block_ready;
    logic [159:0] digest;
    logic         digest_valid;
`ifdef SHA1_ABORT_EN
    logic         abort;
`endif

    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb_q[$];

    sha1_block_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .block_in     (block_in),
        .block_first  (block_first),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .digest       (digest),
        .digest_valid (digest_valid)
`ifdef SHA1_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every digest_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && digest_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 160'd1, 160'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_edge", 160'(edge_cnt), 160'(e.edge_no));
                if (e.chk) check("digest", digest, e.dig);
            end
        end
    end

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    // Offer a block; returns the accept edge number. keep leaves block_valid asserted.
    task automatic send_block(input logic [511:0] blk, input logic first, input bit chk,
                              input logic [159:0] exp, input bit keep, output int acc);
        int   budget;
        exp_t e;
        budget = 300;
        @(negedge clk);
        block_in    = blk;
        block_first = first;
        block_valid = 1'b1;
        while (!block_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("accept_timeout", 160'd0, 160'd1);
        acc       = edge_cnt + 1;
        e.edge_no = acc + 81;
        e.chk     = chk;
        e.dig     = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) block_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 400;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("drain_timeout", 160'(sb_q.size()), 160'd0);
    endtask

    initial begin
        int acc, acc2;
        rst_n       = 1'b0;
        block_in    = '0;
        block_first = 1'b0;
        block_valid = 1'b0;
`ifdef SHA1_ABORT_EN
        abort       = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_ready", 160'(block_ready), 160'd1);
        check("reset_valid", 160'(digest_valid), 160'd0);
        check("reset_digest", digest, 160'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "abc", with ready timing around the final edges
        send_block(BLK_ABC, 1'b1, 1'b1, DIG_ABC, 1'b0, acc);
        wait_edge(acc + 80);
        check("busy_ready_e80", 160'(block_ready), 160'd0);
        check("no_early_pulse", 160'(digest_valid), 160'd0);
        wait_edge(acc + 81);
        check("ready_after_e81", 160'(block_ready), 160'd1);
        drain();
        repeat (5) @(negedge clk);
        check("digest_held", digest, DIG_ABC);

        // empty message
        send_block(BLK_EMPTY, 1'b1, 1'b1, DIG_EMPTY, 1'b0, acc);
        drain();

        // two-block message, back-to-back with block_valid held
        send_block(BLK_TWO1, 1'b1, 1'b0, '0, 1'b1, acc);
        send_block(BLK_TWO2, 1'b0, 1'b1, DIG_TWO, 1'b0, acc2);
        check("b2b_accept_edge", 160'(acc2), 160'(acc + 82));
        drain();

        // busy: a different block offered mid-rounds is ignored
        send_block(BLK_ABC, 1'b1, 1'b1, DIG_ABC, 1'b0, acc);
        wait_edge(acc + 20);
        block_in    = BLK_EMPTY;
        block_valid = 1'b1;
        @(negedge clk);
        check("busy_ready_low", 160'(block_ready), 160'd0);
        block_valid = 1'b0;
        drain();

        // reset at round 40: partial block discarded
        send_block(BLK_EMPTY, 1'b1, 1'b0, '0, 1'b0, acc);
        wait_edge(acc + 40);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check("midrst_ready", 160'(block_ready), 160'd1);
        check("midrst_digest", digest, 160'd0);
        check("midrst_valid", 160'(digest_valid), 160'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (90) @(negedge clk);
        check("midrst_digest_hold", digest, 160'd0);
        send_block(BLK_ABC, 1'b1, 1'b1, DIG_ABC, 1'b0, acc);
        drain();

`ifdef SHA1_ABORT_EN
        // abort a continuation block at round 10
        send_block(BLK_EMPTY, 1'b0, 1'b0, '0, 1'b0, acc);
        wait_edge(acc + 10);
        abort = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", 160'(block_ready), 160'd1);
        repeat (90) @(negedge clk);
        check("abort_digest_kept", digest, DIG_ABC);
        // abort beats block_valid in IDLE
        block_in    = BLK_EMPTY;
        block_first = 1'b1;
        block_valid = 1'b1;
        abort       = 1'b1;
        @(negedge clk);
        check("abort_blocks_accept", 160'(block_ready), 160'd1);
        block_valid = 1'b0;
        abort       = 1'b0;
`endif

        // catch any stray extra block or pulse
        repeat (100) @(negedge clk);
        check("queue_empty", 160'(sb_q.size()), 160'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
